multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Sequencing/decode controller for the multicycle RV32I core. Sits directly upstream of the ALU.
- Decodes the latched instruction and walks a per-instruction state machine.
- Each cycle it drives the ALU control, the operand mux selects and all architectural write enables.
- Consumes the ALU's equal flag and result LSB to resolve branches; handshakes with a shared instruction/data memory.

Parameters:
- N, 32, datapath width (only 32 supported; used for documentation/constants).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- instr  input  32  instruction register contents (valid from DECODE onward).
- mem_ready  input  1  memory completes the current access this cycle.
- alu_equal  input  1  ALU equal flag (a == b).
- alu_result_lsb  input  1  bit 0 of the current ALU result (SLT/SLTU outcome).
- alu_control  output  alu_control_t  operation for the ALU.
- alu_src_a  output  2  00 PC, 01 old_pc, 10 reg A, 11 zero.
- alu_src_b  output  2  00 reg B, 01 immediate, 10 constant 4.
- imm_src  output  3  000 I, 001 S, 010 B, 011 U, 100 J; decoded combinationally from instr[6:0].
- result_src  output  2  00 ALUOut register, 01 memory data, 10 ALU result direct.
- adr_src  output  1  memory address: 0 PC, 1 result.
- mem_req  output  1  memory access active.
- mem_wren  output  1  memory write.
- ir_write  output  1  latch instruction and old_pc.
- pc_write  output  1  update PC from result.
- reg_write  output  1  register file write of rd.
- illegal_instr  output  1  sticky error flag.

Behaviour:
- Reset (rst low, async):
  - state forced to FETCH.
  - pc_write, ir_write, reg_write, mem_req and mem_wren forced 0; illegal_instr cleared.
  - The first active edge after release executes FETCH.
- Mid-instruction reset aborts with no partial write.
- All outputs are Moore functions of state plus instr. mem_ready qualifies the writes listed below.
- FETCH:
  - Outputs: adr_src=0, mem_req=1, a=PC, b=4, ADD, result_src=10.
  - While mem_ready=0: hold; ir_write=0, pc_write=0.
  - Cycle with mem_ready=1: ir_write=1 and pc_write=1, then go to DECODE.
- DECODE:
  - Computes the branch target: a=old_pc, b=imm, ADD.
  - Next state by opcode:
    - 0110011 -> EXE_R
    - 0010011 -> EXE_I
    - 0000011 / 0100011 -> MEMADR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR_ADR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - anything else -> ERROR
- MEMADR: a=regA, b=imm, ADD. Next MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: adr_src=1, result_src=00, mem_req=1. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_req=1, mem_wren=1 for every cycle until mem_ready. Then FETCH.
- EXE_R: a=regA, b=regB. Next ALUWB.
- EXE_I: a=regA, b=imm. Next ALUWB.
- ALU op for EXE_R/EXE_I, selected by funct3:
  - 000 ADD; SUB only when R-type and instr[30]=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101 SRL, or SRA when instr[30]=1 (both R and I).
  - 110 OR, 111 AND.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BRANCH:
  - a=regA, b=regB, result_src=00 (ALUOut holds the target).
  - ALU op and taken condition by funct3:
    - 000 SUB, taken if equal.
    - 001 SUB, taken if !equal.
    - 100 SLT, taken if lsb.
    - 101 SLT, taken if !lsb.
    - 110 SLTU, taken if lsb.
    - 111 SLTU, taken if !lsb.
  - pc_write = taken. Next FETCH.
  - funct3 010/011 -> ERROR from DECODE.
- JAL: a=old_pc, b=4, ADD, result_src=00, pc_write=1. Next ALUWB (writes old_pc+4).
- JALR_ADR: a=regA, b=imm, ADD. Next JALR.
- JALR: a=old_pc, b=4, ADD, result_src=00, pc_write=1. Next ALUWB.
- LUI: a=zero, b=imm(U), ADD. Next ALUWB.
- AUIPC: a=old_pc, b=imm(U), ADD. Next ALUWB.
- ERROR: all write enables 0, illegal_instr=1. Terminal until reset.
- Default outputs in every state: alu_control=ADD and all enables 0 unless stated above.
- Latency with mem_ready tied high:
  - R/I/LUI/AUIPC/JAL/store: 4 cycles.
  - Load/JALR: 5 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds 1.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH, DECODE, EXE_R (alu_control=ADD), ALUWB with reg_write=1 exactly once; pc_write only in FETCH.
- sub 0x402081B3, then srai 0x4020D193 -> EXE stage shows SUB, then SRA with alu_src_b=01.
- bne 0x00209463: alu_equal=1 -> pc_write stays 0 in BRANCH; repeat with alu_equal=0 -> pc_write=1 in BRANCH; both return to FETCH after 3 cycles.
- sw 0x0020A023 with mem_ready low for 3 cycles in MEMWRITE -> mem_wren=1 for 4 consecutive cycles, adr_src=1, reg_write never asserted.
- Opcode 0x0000007F -> ERROR after DECODE, illegal_instr=1 and held; all enables 0 until rst pulses low.
- Drop rst during MEMREAD of lw 0x0000A183 -> outputs clear asynchronously, no reg_write; after release, FETCH restarts with mem_req=1.

Source files
------------

// File: rtl/multicycle_control.sv
// Sequencing/decode controller for the multicycle RV32I core.
// Walks a per-instruction state machine and drives the ALU control,
// operand mux selects, memory handshake and architectural write enables.

package multicycle_control_pkg;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND
   } alu_control_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] instr,
   input  logic         mem_ready,
   input  logic         alu_equal,
   input  logic         alu_result_lsb,
   output alu_control_t alu_control,
   output logic [1:0]   alu_src_a,
   output logic [1:0]   alu_src_b,
   output logic [2:0]   imm_src,
   output logic [1:0]   result_src,
   output logic         adr_src,
   output logic         mem_req,
   output logic         mem_wren,
   output logic         ir_write,
   output logic         pc_write,
   output logic         reg_write,
   output logic         illegal_instr
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXE_R,
      S_EXE_I,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_JALR_ADR,
      S_JALR,
      S_LUI,
      S_AUIPC,
      S_ERROR
   } state_t;

   // Operand mux encodings.
   localparam logic [1:0] A_PC     = 2'b00;
   localparam logic [1:0] A_OLD_PC = 2'b01;
   localparam logic [1:0] A_REG    = 2'b10;
   localparam logic [1:0] A_ZERO   = 2'b11;
   localparam logic [1:0] B_REG    = 2'b00;
   localparam logic [1:0] B_IMM    = 2'b01;
   localparam logic [1:0] B_FOUR   = 2'b10;
   localparam logic [1:0] R_ALUOUT = 2'b00;
   localparam logic [1:0] R_MEM    = 2'b01;
   localparam logic [1:0] R_ALU    = 2'b10;

   state_t     state;
   state_t     state_next;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       bit30;
   logic       branch_taken;
   logic       unused_instr_bits;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign bit30  = instr[30];

   // Fields outside opcode/funct3/bit 30 belong to the datapath, not to sequencing.
   assign unused_instr_bits = ^{instr[N-1:31], instr[29:15], instr[11:7]};

   // Branch condition: funct3[2] picks compare-less-than over equality, funct3[0] inverts.
   assign branch_taken = (funct3[2] ? alu_result_lsb : alu_equal) ^ funct3[0];

   // ALU operation for register/immediate arithmetic; SUB only exists for R-type.
   function automatic alu_control_t exe_op(input logic [2:0] f3, input logic b30,
                                           input logic is_r);
      case (f3)
         3'b000:  exe_op = (is_r && b30) ? ALU_SUB : ALU_ADD;
         3'b001:  exe_op = ALU_SLL;
         3'b010:  exe_op = ALU_SLT;
         3'b011:  exe_op = ALU_SLTU;
         3'b100:  exe_op = ALU_XOR;
         3'b101:  exe_op = b30 ? ALU_SRA : ALU_SRL;
         3'b110:  exe_op = ALU_OR;
         default: exe_op = ALU_AND;
      endcase
   endfunction

   // State register: reset lands in FETCH so the first edge after release fetches.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_FETCH;
      else      state <= state_next;
   end

   // Next-state logic: per-instruction walk, memory states hold until mem_ready.
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:    if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_R:      state_next = S_EXE_R;
               OP_I:      state_next = S_EXE_I;
               OP_LOAD,
               OP_STORE:  state_next = S_MEMADR;
               OP_BRANCH: state_next = (funct3[2:1] == 2'b01) ? S_ERROR : S_BRANCH;
               OP_JAL:    state_next = S_JAL;
               OP_JALR:   state_next = S_JALR_ADR;
               OP_LUI:    state_next = S_LUI;
               OP_AUIPC:  state_next = S_AUIPC;
               default:   state_next = S_ERROR;
            endcase
         end
         S_MEMADR:   state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
         S_EXE_R,
         S_EXE_I:    state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_BRANCH:   state_next = S_FETCH;
         S_JAL:      state_next = S_ALUWB;
         S_JALR_ADR: state_next = S_JALR;
         S_JALR:     state_next = S_ALUWB;
         S_LUI,
         S_AUIPC:    state_next = S_ALUWB;
         default:    state_next = S_ERROR;
      endcase
   end

   // Immediate format follows the opcode alone so the datapath can extend it early.
   always_comb begin
      case (opcode)
         OP_STORE:        imm_src = 3'b001;
         OP_BRANCH:       imm_src = 3'b010;
         OP_LUI,
         OP_AUIPC:        imm_src = 3'b011;
         OP_JAL:          imm_src = 3'b100;
         default:         imm_src = 3'b000;
      endcase
   end

   // Output decode per state; writes are squashed while reset is held.
   // NOTE: every output gets a default first so no path through the case can infer a latch.
   always_comb begin
      alu_control   = ALU_ADD;
      alu_src_a     = A_PC;
      alu_src_b     = B_REG;
      result_src    = R_ALUOUT;
      adr_src       = 1'b0;
      mem_req       = 1'b0;
      mem_wren      = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_a  = A_PC;
            alu_src_b  = B_FOUR;
            result_src = R_ALU;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = A_OLD_PC;
            alu_src_b = B_IMM;
         end
         S_MEMADR, S_JALR_ADR: begin
            alu_src_a = A_REG;
            alu_src_b = B_IMM;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            mem_req = 1'b1;
         end
         S_MEMWB: begin
            result_src = R_MEM;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src  = 1'b1;
            mem_req  = 1'b1;
            mem_wren = 1'b1;
         end
         S_EXE_R: begin
            alu_src_a   = A_REG;
            alu_src_b   = B_REG;
            alu_control = exe_op(funct3, bit30, 1'b1);
         end
         S_EXE_I: begin
            alu_src_a   = A_REG;
            alu_src_b   = B_IMM;
            alu_control = exe_op(funct3, bit30, 1'b0);
         end
         S_ALUWB: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a   = A_REG;
            alu_src_b   = B_REG;
            alu_control = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
            pc_write    = branch_taken;
         end
         S_JAL, S_JALR: begin
            alu_src_a = A_OLD_PC;
            alu_src_b = B_FOUR;
            pc_write  = 1'b1;
         end
         S_LUI: begin
            alu_src_a = A_ZERO;
            alu_src_b = B_IMM;
         end
         S_AUIPC: begin
            alu_src_a = A_OLD_PC;
            alu_src_b = B_IMM;
         end
         default: illegal_instr = 1'b1;
      endcase
      if (!rst) begin
         mem_req       = 1'b0;
         mem_wren      = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         reg_write     = 1'b0;
         illegal_instr = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A reference model expands
// each instruction into its expected cycle plan and compares every cycle.

module tb_multicycle_control;
   import multicycle_control_pkg::*;

   logic         clk;
   logic         rst;
   logic [31:0]  instr;
   logic         mem_ready;
   logic         alu_equal;
   logic         alu_result_lsb;
   alu_control_t alu_control;
   logic [1:0]   alu_src_a;
   logic [1:0]   alu_src_b;
   logic [2:0]   imm_src;
   logic [1:0]   result_src;
   logic         adr_src;
   logic         mem_req;
   logic         mem_wren;
   logic         ir_write;
   logic         pc_write;
   logic         reg_write;
   logic         illegal_instr;

   int n_checks = 0;
   int n_fail   = 0;

   // Observations from the most recent run_instr call.
   int obs_cycles;
   int obs_wren;
   int obs_rw;
   int obs_pcw;

   multicycle_control #(.N(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .instr          (instr),
      .mem_ready      (mem_ready),
      .alu_equal      (alu_equal),
      .alu_result_lsb (alu_result_lsb),
      .alu_control    (alu_control),
      .alu_src_a      (alu_src_a),
      .alu_src_b      (alu_src_b),
      .imm_src        (imm_src),
      .result_src     (result_src),
      .adr_src        (adr_src),
      .mem_req        (mem_req),
      .mem_wren       (mem_wren),
      .ir_write       (ir_write),
      .pc_write       (pc_write),
      .reg_write      (reg_write),
      .illegal_instr  (illegal_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------

   typedef struct {
      string        name;
      alu_control_t op;
      logic [1:0]   a;
      logic [1:0]   b;
      logic [1:0]   rs;
      logic         adr;
      logic         req;
      logic         wren;
      logic         rw;
      logic         pcw;
      bit           wait_mem;
      bit           fetch;
      bit           branch;
      bit           ill;
   } step_t;

   step_t plan[$];

   function automatic step_t mk(string name, alu_control_t op, logic [1:0] a, logic [1:0] b,
                                logic [1:0] rs, logic adr, logic req, logic wren, logic rw,
                                logic pcw, bit wait_mem, bit fetch, bit branch, bit ill);
      step_t s;
      s.name = name; s.op = op; s.a = a; s.b = b; s.rs = rs; s.adr = adr; s.req = req;
      s.wren = wren; s.rw = rw; s.pcw = pcw; s.wait_mem = wait_mem; s.fetch = fetch;
      s.branch = branch; s.ill = ill;
      return s;
   endfunction

   function automatic logic [2:0] ref_imm(logic [6:0] opc);
      if (opc == OP_STORE)                    return 3'b001;
      if (opc == OP_BRANCH)                   return 3'b010;
      if (opc == OP_LUI || opc == OP_AUIPC)   return 3'b011;
      if (opc == OP_JAL)                      return 3'b100;
      return 3'b000;
   endfunction

   function automatic alu_control_t ref_exe_op(logic [31:0] ins, bit is_r);
      alu_control_t base [8];
      alu_control_t op;
      base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      op = base[ins[14:12]];
      if (ins[14:12] == 3'd0 && is_r && ins[30]) op = ALU_SUB;
      if (ins[14:12] == 3'd5 && ins[30])         op = ALU_SRA;
      return op;
   endfunction

   function automatic logic ref_taken(logic [2:0] f3, logic eq, logic lsb);
      case (f3)
         3'd0:       return eq;
         3'd1:       return !eq;
         3'd4, 3'd6: return lsb;
         default:    return !lsb;
      endcase
   endfunction

   function automatic logic [19:0] pack(alu_control_t op, logic [1:0] a, logic [1:0] b,
                                        logic [2:0] imm, logic [1:0] rs, logic adr,
                                        logic req, logic wren, logic irw, logic pcw,
                                        logic rw, logic ill);
      return {op, a, b, imm, rs, adr, req, wren, irw, pcw, rw, ill};
   endfunction

   // Expands one instruction into the cycle-by-cycle outputs it must produce.
   function automatic void build_plan(logic [31:0] ins);
      logic [6:0] opc;
      logic [2:0] f3;
      alu_control_t br_op [8];
      step_t aluwb;
      opc = ins[6:0];
      f3  = ins[14:12];
      br_op = '{ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD, ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU};
      aluwb = mk("aluwb", ALU_ADD, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      plan.delete();
      plan.push_back(mk("fetch", ALU_ADD, 2'b00, 2'b10, 2'b10, 0, 1, 0, 0, 0, 1, 1, 0, 0));
      plan.push_back(mk("decode", ALU_ADD, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      if (opc == OP_R) begin
         plan.push_back(mk("exe_r", ref_exe_op(ins, 1), 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         plan.push_back(aluwb);
      end else if (opc == OP_I) begin
         plan.push_back(mk("exe_i", ref_exe_op(ins, 0), 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         plan.push_back(aluwb);
      end else if (opc == OP_LOAD) begin
         plan.push_back(mk("memadr", ALU_ADD, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         plan.push_back(mk("memread", ALU_ADD, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 0, 0));
         plan.push_back(mk("memwb", ALU_ADD, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      end else if (opc == OP_STORE) begin
         plan.push_back(mk("memadr", ALU_ADD, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         plan.push_back(mk("memwrite", ALU_ADD, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0, 0));
      end else if (opc == OP_BRANCH && f3 != 3'd2 && f3 != 3'd3) begin
         plan.push_back(mk("branch", br_op[f3], 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      end else if (opc == OP_JAL) begin
         plan.push_back(mk("jal", ALU_ADD, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0));
         plan.push_back(aluwb);
      end else if (opc == OP_JALR) begin
         plan.push_back(mk("jalr_adr", ALU_ADD, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         plan.push_back(mk("jalr", ALU_ADD, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0));
         plan.push_back(aluwb);
      end else if (opc == OP_LUI) begin
         plan.push_back(mk("lui", ALU_ADD, 2'b11, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         plan.push_back(aluwb);
      end else if (opc == OP_AUIPC) begin
         plan.push_back(mk("auipc", ALU_ADD, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         plan.push_back(aluwb);
      end else begin
         for (int k = 0; k < 4; k++)
            plan.push_back(mk("error", ALU_ADD, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
   endfunction

   function automatic bit is_illegal(logic [31:0] ins);
      build_plan(ins);
      return plan[plan.size()-1].ill;
   endfunction

   // ---------------- stimulus / checking ----------------

   // mem_wait < 0: random memory latency; otherwise fetch is immediate and
   // memory steps stall exactly mem_wait cycles. eq < 0: random alu_equal.
   // abort_step >= 0: return after the first cycle of that step, mem_ready low.
   task automatic run_instr(input logic [31:0] ins, input int mem_wait, input int eq,
                            input int abort_step, input string tag);
      logic [19:0] act, exp;
      logic        irw_e, pcw_e;
      build_plan(ins);
      obs_cycles = 0; obs_wren = 0; obs_rw = 0; obs_pcw = 0;
      for (int i = 0; i < plan.size(); i++) begin
         int waited;
         bit done;
         waited = 0;
         done   = 0;
         while (!done) begin
            @(negedge clk);
            if (i == 0) instr = ins;
            alu_equal      = (eq < 0) ? 1'($urandom_range(0, 1)) : eq[0];
            alu_result_lsb = 1'($urandom_range(0, 1));
            if (i == abort_step)              mem_ready = 1'b0;
            else if (!plan[i].wait_mem)       mem_ready = 1'($urandom_range(0, 1));
            else if (mem_wait < 0)            mem_ready = (waited >= 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
            else if (plan[i].fetch)           mem_ready = 1'b1;
            else                              mem_ready = (waited >= mem_wait);
            #1;
            irw_e = plan[i].fetch & mem_ready;
            pcw_e = plan[i].fetch  ? mem_ready :
                    plan[i].branch ? ref_taken(ins[14:12], alu_equal, alu_result_lsb) :
                                     plan[i].pcw;
            exp = pack(plan[i].op, plan[i].a, plan[i].b, ref_imm(ins[6:0]), plan[i].rs,
                       plan[i].adr, plan[i].req, plan[i].wren, irw_e, pcw_e, plan[i].rw,
                       plan[i].ill);
            act = pack(alu_control, alu_src_a, alu_src_b, imm_src, result_src, adr_src,
                       mem_req, mem_wren, ir_write, pc_write, reg_write, illegal_instr);
            n_checks++;
            if (act !== exp) begin
               n_fail++;
               $display("FAIL %s step=%s instr=%08h got=%05h want=%05h", tag, plan[i].name,
                        ins, act, exp);
            end
            obs_cycles++;
            obs_wren += int'(mem_wren);
            obs_rw   += int'(reg_write);
            obs_pcw  += int'(pc_write);
            if (i == abort_step) return;
            if (obs_cycles > 60) begin
               n_fail++;
               $display("FAIL %s cycle budget exceeded instr=%08h", tag, ins);
               return;
            end
            done = !plan[i].wait_mem || mem_ready;
            waited++;
         end
      end
   endtask

   // Pulses reset, checks enables are cleared while held and FETCH resumes after release.
   task automatic test_reset(input string tag);
      logic [19:0] act, exp;
      @(negedge clk);
      #1 rst = 1'b0;
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if ({mem_req, mem_wren, ir_write, pc_write, reg_write, illegal_instr} !== 6'b0) begin
         n_fail++;
         $display("FAIL %s enables_in_reset got=%06b want=000000", tag,
                  {mem_req, mem_wren, ir_write, pc_write, reg_write, illegal_instr});
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      exp = pack(ALU_ADD, 2'b00, 2'b10, ref_imm(instr[6:0]), 2'b10, 0, 1, 0, 0, 0, 0, 0);
      act = pack(alu_control, alu_src_a, alu_src_b, imm_src, result_src, adr_src,
                 mem_req, mem_wren, ir_write, pc_write, reg_write, illegal_instr);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s fetch_after_release got=%05h want=%05h", tag, act, exp);
      end
   endtask

   task automatic expect_int(input string tag, input int got, input int want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic test_alu_ops();
      run_instr(32'h002081B3, 0, -1, -1, "add");
      expect_int("add_cycles", obs_cycles, 4);
      expect_int("add_reg_write", obs_rw, 1);
      expect_int("add_pc_write", obs_pcw, 1);
      run_instr(32'h402081B3, 0, -1, -1, "sub");
      expect_int("sub_cycles", obs_cycles, 4);
      run_instr(32'h4020D193, 0, -1, -1, "srai");
      expect_int("srai_cycles", obs_cycles, 4);
   endtask

   task automatic test_branch();
      run_instr(32'h00209463, 0, 1, -1, "bne_equal");
      expect_int("bne_equal_cycles", obs_cycles, 3);
      expect_int("bne_equal_pc_write", obs_pcw, 1);
      run_instr(32'h00209463, 0, 0, -1, "bne_differ");
      expect_int("bne_differ_cycles", obs_cycles, 3);
      expect_int("bne_differ_pc_write", obs_pcw, 2);
   endtask

   task automatic test_store_wait();
      run_instr(32'h0020A023, 3, -1, -1, "sw_wait");
      expect_int("sw_cycles", obs_cycles, 7);
      expect_int("sw_wren_cycles", obs_wren, 4);
      expect_int("sw_reg_write", obs_rw, 0);
   endtask

   task automatic test_latency();
      run_instr(32'h0000A183, 0, -1, -1, "lw");
      expect_int("lw_cycles", obs_cycles, 5);
      run_instr(32'h000080E7, 0, -1, -1, "jalr");
      expect_int("jalr_cycles", obs_cycles, 5);
      run_instr(32'h008000EF, 0, -1, -1, "jal");
      expect_int("jal_cycles", obs_cycles, 4);
      run_instr(32'h123450B7, 0, -1, -1, "lui");
      expect_int("lui_cycles", obs_cycles, 4);
   endtask

   task automatic test_illegal();
      run_instr(32'h0000007F, 0, -1, -1, "illegal");
      expect_int("illegal_pc_write", obs_pcw, 1);
      test_reset("illegal_clear");
      run_instr(32'h0000A063 | (32'd2 << 12), 0, -1, -1, "branch_f3_010");
      test_reset("branch_f3_clear");
   endtask

   task automatic test_reset_midflight();
      run_instr(32'h0000A183, -1, -1, 3, "lw_abort");
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if ({mem_req, mem_wren, ir_write, pc_write, reg_write, illegal_instr} !== 6'b0) begin
         n_fail++;
         $display("FAIL lw_abort async_clear got=%06b want=000000",
                  {mem_req, mem_wren, ir_write, pc_write, reg_write, illegal_instr});
      end
      expect_int("lw_abort_reg_write", obs_rw, 0);
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if ({mem_req, reg_write} !== 2'b00) begin
         n_fail++;
         $display("FAIL lw_abort held_reset got=%02b want=00", {mem_req, reg_write});
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({mem_req, alu_src_b, result_src, ir_write, pc_write} !== {1'b1, 2'b10, 2'b10, 2'b00}) begin
         n_fail++;
         $display("FAIL lw_abort restart_fetch got=%07b want=1101000",
                  {mem_req, alu_src_b, result_src, ir_write, pc_write});
      end
      run_instr(32'h002081B3, -1, -1, -1, "add_after_abort");
   endtask

   task automatic test_random_mix();
      logic [6:0] opcs [10];
      logic [31:0] ins;
      opcs = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
               7'b1111111};
      for (int n = 0; n < 60; n++) begin
         ins = $urandom;
         ins[6:0] = opcs[$urandom_range(0, 9)];
         run_instr(ins, -1, -1, -1, "random");
         if (is_illegal(ins)) test_reset("random_clear");
      end
   endtask

   initial begin
      rst = 1'b0;
      instr = 32'h0;
      mem_ready = 1'b0;
      alu_equal = 1'b0;
      alu_result_lsb = 1'b0;
      #2;
      n_checks++;
      if ({mem_req, mem_wren, ir_write, pc_write, reg_write, illegal_instr} !== 6'b0) begin
         n_fail++;
         $display("FAIL power_on_reset got=%06b want=000000",
                  {mem_req, mem_wren, ir_write, pc_write, reg_write, illegal_instr});
      end
      test_reset("initial");
      test_alu_ops();
      test_branch();
      test_store_wait();
      test_latency();
      test_illegal();
      test_reset_midflight();
      test_random_mix();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
